// File: rtl/dma_word_writer.sv
// dma_word_writer: buffers SPI words in a FIFO and writes them to memory.
// Optional DMA_WRITER_BSWAP_EN byte-reverses each written word.
module dma_word_writer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] dma_addr,
  input  logic [15:0] dma_len,
  input  logic        dma_run,
  input  logic        dma_strobe,
  input  logic [31:0] dma_data,
  output logic        dma_done,
  output logic        busy,
  output logic        error,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic [3:0]  mem_bsel,
  input  logic        mem_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic [31:0] fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [15:0] remaining_q, remaining_d;
  logic [31:0] next_addr_q, next_addr_d;
  logic [15:0] next_len_q, next_len_d;
  logic        sh_valid_q, sh_valid_d;
  logic        error_q, error_d;
  logic        done_q, done_d;
  logic        done2_q, done2_d;

  logic        active, empty, full;
  logic        hs, last, push, pop;
  logic        run_idle, zero_idle;
  logic        run_act, sh_take, sh_rej;
  logic        promo_valid;
  logic [31:0] promo_addr;
  logic [15:0] promo_len;
  logic [31:0] addr_al;
  logic [AW:0] cnt_after;
  logic        to_idle, leftover;
  logic [31:0] head;

  // Handshake and job-control decode shared by all processes
  always_comb begin
    active      = (state_q == ACTIVE);
    empty       = (cnt_q == '0);
    full        = (cnt_q == DEPTH);
    head        = fifo_q[rptr_q];
    addr_al     = dma_addr & ~32'h3;
    hs          = active & ~empty & mem_ready;
    last        = hs & (remaining_q == 16'd1);
    pop         = hs;
    push        = active & dma_strobe & (~full | pop);
    run_idle    = ~active & dma_run & (dma_len != 16'd0);
    zero_idle   = ~active & dma_run & (dma_len == 16'd0);
    run_act     = active & dma_run;
    sh_take     = run_act & ~sh_valid_q;
    sh_rej      = run_act & sh_valid_q;
    promo_valid = sh_valid_q | sh_take;
    promo_addr  = sh_valid_q ? next_addr_q : addr_al;
    promo_len   = sh_valid_q ? next_len_q : dma_len;
    cnt_after   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    to_idle     = last & ~(promo_valid & (promo_len != 16'd0));
    leftover    = to_idle & (cnt_after != '0);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (run_idle) state_d = ACTIVE;
      ACTIVE: if (to_idle)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointers, job registers, error and done pulse
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_after;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    next_addr_d = next_addr_q;
    next_len_d  = next_len_q;
    sh_valid_d  = sh_valid_q;
    error_d     = error_q;
    done_d      = zero_idle | last | done2_q;
    done2_d     = last & promo_valid & (promo_len == 16'd0);

    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (to_idle) begin
      cnt_d  = '0;
      rptr_d = wptr_d;
    end

    if (run_idle) begin
      cur_addr_d  = addr_al;
      remaining_d = dma_len;
    end else if (hs) begin
      if (last && promo_valid) begin
        cur_addr_d  = promo_addr;
        remaining_d = promo_len;
      end else begin
        cur_addr_d  = cur_addr_q + 32'd4;
        remaining_d = remaining_q - 16'd1;
      end
    end

    if (sh_take && !last) begin
      next_addr_d = addr_al;
      next_len_d  = dma_len;
      sh_valid_d  = 1'b1;
    end
    if (last) sh_valid_d = 1'b0;

    if (run_idle) error_d = 1'b0;
    if ((dma_strobe && !push) || sh_rej || leftover)
      error_d = 1'b1;
  end

  // Control and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      next_addr_q <= '0;
      next_len_q  <= '0;
      sh_valid_q  <= 1'b0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      done2_q     <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      next_addr_q <= next_addr_d;
      next_len_q  <= next_len_d;
      sh_valid_q  <= sh_valid_d;
      error_q     <= error_d;
      done_q      <= done_d;
      done2_q     <= done2_d;
    end
  end

  // FIFO storage; contents are meaningless outside the count window
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= dma_data;
  end

  // Output logic
  always_comb begin
    busy     = active;
    mem_wen  = active & ~empty;
    mem_addr = mem_wen ? cur_addr_q : 32'd0;
`ifdef DMA_WRITER_BSWAP_EN
    mem_wdata = mem_wen ?
      {head[7:0], head[15:8], head[23:16], head[31:24]} : 32'd0;
`else
    mem_wdata = mem_wen ? head : 32'd0;
`endif
    mem_bsel = 4'hF;
    dma_done = done_q;
    error    = error_q;
  end

endmodule
